// File: rtl/pipeline_pkg.sv
// Shared pipeline-stage types: payload bundle, statistics record, pointer wrap helper.
package pipeline_pkg;

    localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] stall;
        logic [31:0] nullified;
    } stage_stats_t;

    // Inter-stage payload; DATA_W of a stage register defaults to its width.
    typedef struct packed {
        logic [31:0] word;
    } stage_payload_t;

    localparam int PAYLOAD_W = $bits(stage_payload_t);

    // Increment with wrap at depth-1, so non-power-of-2 depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_stage_stats.sv
// Saturating stall-cycle and nullified-beat counters for one pipeline stage register.
module pipeline_stage_stats
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_nullify,
    input  logic             i_in_valid,
    input  logic [CNT_W-1:0] i_occupancy,
    output stage_stats_t     o_stats
);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? SAT32 : sum[31:0];
    endfunction

    logic [31:0] r_stall;
    logic [31:0] r_null;
    logic [31:0] w_null_inc;

    // A flush discards every held entry plus the beat offered in the same cycle.
    assign w_null_inc = 32'(i_occupancy) + 32'(i_in_valid);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall <= 32'd0;
            r_null  <= 32'd0;
        end else begin
            if (i_stall && !i_nullify) begin
                r_stall <= sat_add(r_stall, 32'd1);
            end
            if (i_nullify) begin
                r_null <= sat_add(r_null, w_null_inc);
            end
        end
    end

    assign o_stats = '{stall: r_stall, nullified: r_null};

endmodule

// File: rtl/pipeline_skid_stage.sv
// DEPTH-entry elastic pipeline stage register with valid/ready, stall and nullify.
// Optional statistics counters are built when PIPELINE_SKID_STAGE_STATS_EN is defined.
module pipeline_skid_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              nullify,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  occupancy,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_null
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_occ;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Handshake outputs depend only on local state and stall, never on out_ready.
    assign w_full    = (r_occ == CNT_W'(DEPTH));
    assign w_empty   = (r_occ == '0);
    assign in_ready  = !stall && !w_full;
    assign out_valid = !stall && !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign occupancy = r_occ;

    assign w_push = in_valid && in_ready && !nullify;
    assign w_pop  = out_valid && out_ready && !nullify;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (nullify) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

`ifdef PIPELINE_SKID_STAGE_STATS_EN
    stage_stats_t w_stats;

    pipeline_stage_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_stall     (stall),
        .i_nullify   (nullify),
        .i_in_valid  (in_valid),
        .i_occupancy (r_occ),
        .o_stats     (w_stats)
    );

    assign stat_stall = w_stats.stall;
    assign stat_null  = w_stats.nullified;
`else
    assign stat_stall = 32'd0;
    assign stat_null  = 32'd0;
`endif

    a_occ_range: assert property (@(posedge clk) disable iff (reset)
        r_occ <= CNT_W'(DEPTH));
    a_wr_ptr_range: assert property (@(posedge clk) disable iff (reset)
        32'(r_wr_ptr) < 32'(DEPTH));
    a_rd_ptr_range: assert property (@(posedge clk) disable iff (reset)
        32'(r_rd_ptr) < 32'(DEPTH));

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Bench for pipeline_skid_stage: directed vector table on DEPTH=2, hand sequences, and
// randomized traffic on DEPTH=2 and DEPTH=3 instances against a queue model.
module tb_pipeline_skid_stage;

`ifdef PIPELINE_SKID_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        nullify = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;

    logic        ir  [2];
    logic        ov  [2];
    logic [31:0] od  [2];
    logic [1:0]  occ [2];
    logic [31:0] sst [2];
    logic [31:0] snl [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_skid_stage #(.DATA_W(32), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .nullify(nullify),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .occupancy(occ[0]), .stat_stall(sst[0]), .stat_null(snl[0])
    );

    pipeline_skid_stage #(.DATA_W(32), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .stall(stall), .nullify(nullify),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .occupancy(occ[1]), .stat_stall(sst[1]), .stat_null(snl[1])
    );

    typedef struct {
        logic        st;
        logic        nu;
        logic        iv;
        logic [31:0] id;
        logic        orr;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[19];

    logic [31:0] mq [2][$];
    longint      m_stall;
    longint      m_null [2];

    function automatic vec_t mk(input logic st, input logic nu, input logic iv,
                                input logic [31:0] id, input logic orr,
                                input logic e_ir, input logic e_ov,
                                input logic [31:0] e_od, input logic [1:0] e_occ);
        vec_t v;
        v.st = st; v.nu = nu; v.iv = iv; v.id = id; v.orr = orr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic nu, input logic iv,
                         input logic [31:0] id, input logic orr);
        @(negedge clk);
        stall = st; nullify = nu; in_valid = iv; in_data = id; out_ready = orr;
        #1;
    endtask

    task automatic chk2(input string nm, input logic e_ir, input logic e_ov,
                        input logic [31:0] e_od, input logic [1:0] e_occ);
        chk({nm, "_in_ready"},  32'(ir[0]),  32'(e_ir));
        chk({nm, "_out_valid"}, 32'(ov[0]),  32'(e_ov));
        chk({nm, "_out_data"},  od[0],       e_od);
        chk({nm, "_occupancy"}, 32'(occ[0]), 32'(e_occ));
    endtask

    initial begin
        //              st nu iv  data         or  ir ov  out_data     occ
        tbl[0]  = mk(0, 0, 1, 32'hA1, 0,  1, 0, 32'h00, 2'd0);
        tbl[1]  = mk(0, 0, 1, 32'hA2, 0,  1, 1, 32'hA1, 2'd1);
        tbl[2]  = mk(0, 0, 0, 32'h00, 0,  0, 1, 32'hA1, 2'd2);
        tbl[3]  = mk(0, 0, 1, 32'hEE, 1,  0, 1, 32'hA1, 2'd2);
        tbl[4]  = mk(0, 0, 0, 32'h00, 1,  1, 1, 32'hA2, 2'd1);
        tbl[5]  = mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 2'd0);
        tbl[6]  = mk(0, 0, 1, 32'h55, 0,  1, 0, 32'h00, 2'd0);
        tbl[7]  = mk(1, 0, 1, 32'h66, 1,  0, 0, 32'h55, 2'd1);
        tbl[8]  = mk(1, 0, 1, 32'h66, 1,  0, 0, 32'h55, 2'd1);
        tbl[9]  = mk(1, 0, 1, 32'h66, 1,  0, 0, 32'h55, 2'd1);
        tbl[10] = mk(0, 0, 0, 32'h00, 0,  1, 1, 32'h55, 2'd1);
        tbl[11] = mk(0, 0, 1, 32'h88, 0,  1, 1, 32'h55, 2'd1);
        tbl[12] = mk(0, 1, 1, 32'h77, 0,  0, 1, 32'h55, 2'd2);
        tbl[13] = mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 2'd0);
        tbl[14] = mk(0, 1, 1, 32'h99, 1,  1, 0, 32'h00, 2'd0);
        tbl[15] = mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 2'd0);
        tbl[16] = mk(0, 0, 1, 32'hAB, 0,  1, 0, 32'h00, 2'd0);
        tbl[17] = mk(1, 1, 1, 32'hCD, 1,  0, 0, 32'hAB, 2'd1);
        tbl[18] = mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 2'd0);

        // Reset state, with reset still asserted.
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_in_ready", k),  32'(ir[k]),  32'd1);
            chk($sformatf("rst%0d_out_valid", k), 32'(ov[k]),  32'd0);
            chk($sformatf("rst%0d_out_data", k),  od[k],       32'd0);
            chk($sformatf("rst%0d_occupancy", k), 32'(occ[k]), 32'd0);
            chk($sformatf("rst%0d_stat_stall", k), sst[k],     32'd0);
            chk($sformatf("rst%0d_stat_null", k),  snl[k],     32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].st, tbl[i].nu, tbl[i].iv, tbl[i].id, tbl[i].orr);
            chk2($sformatf("tbl%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_occ);
        end
        chk("tbl_stat_stall", sst[0], STATS ? 32'd3 : 32'd0);
        chk("tbl_stat_null",  snl[0], STATS ? 32'd6 : 32'd0);

        // Streaming: one beat in and one out per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 32'h10 + 32'(i), 1);
            chk2($sformatf("stream%0d", i), 1'b1, i != 0,
                 (i == 0) ? 32'd0 : 32'h10 + 32'(i - 1), (i == 0) ? 2'd0 : 2'd1);
        end
        drive(0, 0, 0, 32'd0, 1);
        chk2("stream_tail", 1'b1, 1'b1, 32'h1F, 2'd1);
        drive(0, 0, 0, 32'd0, 1);
        chk2("stream_drained", 1'b1, 1'b0, 32'd0, 2'd0);

        // Asynchronous reset between edges with two beats held.
        drive(0, 0, 1, 32'hC1, 0);
        drive(0, 0, 1, 32'hC2, 0);
        drive(0, 0, 0, 32'd0, 0);
        chk2("prerst", 1'b0, 1'b1, 32'hC1, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        chk2("midrst", 1'b1, 1'b0, 32'd0, 2'd0);
        chk("midrst_stat_stall", sst[0], 32'd0);
        chk("midrst_stat_null",  snl[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic on both depths against a FIFO-queue model.
        m_stall = 0;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_null[k] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            stall     = ($urandom_range(0, 9) == 0);
            nullify   = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_data   = $urandom;
            #1;
            for (int k = 0; k < 2; k++) begin
                int    dep;
                int    sz;
                logic  e_ir;
                logic  e_ov;
                logic [31:0] e_od;
                dep  = k + 2;
                sz   = mq[k].size();
                e_ir = !stall && (sz < dep);
                e_ov = !stall && (sz != 0);
                e_od = (sz != 0) ? mq[k][0] : 32'd0;
                chk($sformatf("rnd%0d_d%0d_in_ready", c, dep),  32'(ir[k]),  32'(e_ir));
                chk($sformatf("rnd%0d_d%0d_out_valid", c, dep), 32'(ov[k]),  32'(e_ov));
                chk($sformatf("rnd%0d_d%0d_out_data", c, dep),  od[k],       e_od);
                chk($sformatf("rnd%0d_d%0d_occupancy", c, dep), 32'(occ[k]), 32'(sz));
                chk($sformatf("rnd%0d_d%0d_stat_stall", c, dep), sst[k],
                    STATS ? 32'(m_stall) : 32'd0);
                chk($sformatf("rnd%0d_d%0d_stat_null", c, dep), snl[k],
                    STATS ? 32'(m_null[k]) : 32'd0);
                if (nullify) begin
                    m_null[k] += sz + int'(in_valid);
                    mq[k].delete();
                end else begin
                    if (e_ov && out_ready) void'(mq[k].pop_front());
                    if (e_ir && in_valid) mq[k].push_back(in_data);
                end
            end
            if (stall && !nullify) m_stall++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
